histo_readout: RTL and testbench

- Downstream consumer of the 1024-bin, 24-bit histogram accumulator.
- On each histogram-done pulse, switches the accumulator to read mode and sweeps bins 0..1023. Each bin read also clears it.
- Streams the counts as one framed packet on a 32-bit valid/ready stream toward the U3V leader/payload packetiser, then returns the accumulator to write (accumulate) mode.
- Never loses a bin under backpressure: every read is destructive, so a small skid FIFO absorbs in-flight reads.

---
 rtl/histo_readout_if.sv | 11 +
 rtl/histo_readout.sv | 279 +++++++++++++++++++++++++++
 tb/tb_histo_readout.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/histo_readout_if.sv
// 32-bit framed valid/ready stream from histo_readout toward the packetiser.
interface histo_readout_if;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic        sof;
    logic        eof;

    modport master (output data, output valid, output sof, output eof, input ready);
    modport slave  (input data, input valid, input sof, input eof, output ready);
endinterface

// File: rtl/histo_readout.sv
// Destructive sweep of the histogram accumulator, streamed as one framed packet per done edge.
// Optional macro HISTO_SUM_EN appends a 32-bit sum-of-counts trailer word.
module histo_readout #(
    parameter int NUM_BINS   = 1024,
    parameter int READ_LAT   = 2,
    parameter int SETTLE     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_histo_done,
    output logic             o_hist_rw,
    output logic [9:0]       o_hist_bin,
    input  logic [23:0]      i_hist_data,
    histo_readout_if.master  m,
    output logic             o_busy,
    output logic [15:0]      o_frame_cnt,
    output logic [7:0]       o_drop_cnt
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [10:0] LAST_BIN = 11'(NUM_BINS - 1);
    localparam logic [CW:0] DEPTH_L  = (CW + 1)'(FIFO_DEPTH);
`ifdef HISTO_SUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_HEADER  = 3'd2,
        S_READ    = 3'd3,
        S_FLUSH   = 3'd4,
        S_DONE    = 3'd5
`ifdef HISTO_SUM_EN
        , S_TRAILER = 3'd6
`endif
    } state_t;

    function automatic logic [CW-1:0] f_ones(input logic [READ_LAT-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        if (p == PW'(FIFO_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    state_t             r_state;
    logic               r_done_q;
    logic [SW-1:0]      r_settle_cnt;
    logic [10:0]        r_next;
    logic [9:0]         r_bin;
    logic               r_rw;
    logic [READ_LAT-1:0] r_vld_sr;
    logic [23:0]        r_fifo [FIFO_DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_cnt;
    logic [10:0]        r_out_idx;
    logic [31:0]        r_data;
    logic               r_valid;
    logic               r_sof;
    logic               r_eof;
    logic               r_busy;
    logic [15:0]        r_frame_cnt;
    logic [7:0]         r_drop_cnt;
`ifdef HISTO_SUM_EN
    logic [31:0]        r_sum;
`endif

    logic          w_rise;
    logic          w_hs;
    logic [CW-1:0] w_inflight;
    logic          w_room;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic          w_flush_done;

    // Every read clears its bin, so an address is only issued when a FIFO slot is reserved for it.
    assign w_rise       = i_histo_done & ~r_done_q;
    assign w_hs         = r_valid & m.ready;
    assign w_inflight   = f_ones(r_vld_sr);
    assign w_room       = ({1'b0, r_cnt} + {1'b0, w_inflight}) < DEPTH_L;
    assign w_issue      = ((r_state == S_HEADER) && w_hs) || ((r_state == S_READ) && w_room);
    assign w_push       = r_vld_sr[READ_LAT-1];
    assign w_pop        = ((r_state == S_READ) || (r_state == S_FLUSH)) && (r_cnt != '0)
                          && (!r_valid || m.ready);
    assign w_flush_done = (r_state == S_FLUSH) && (w_inflight == '0) && (r_cnt == '0)
                          && (!r_valid || m.ready);

    // Sweep sequencer, read pipeline, skid FIFO and registered stream output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_done_q     <= 1'b0;
            r_settle_cnt <= '0;
            r_next       <= 11'd0;
            r_bin        <= 10'd0;
            r_rw         <= 1'b1;
            r_vld_sr     <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_cnt        <= '0;
            r_out_idx    <= 11'd0;
            r_data       <= 32'd0;
            r_valid      <= 1'b0;
            r_sof        <= 1'b0;
            r_eof        <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_cnt  <= 16'd0;
            r_drop_cnt   <= 8'd0;
`ifdef HISTO_SUM_EN
            r_sum        <= 32'd0;
`endif
        end else begin
            r_done_q <= i_histo_done;
            if (w_rise && r_busy && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end

            r_vld_sr[0] <= w_issue;
            for (int i = 1; i < READ_LAT; i++) begin
                r_vld_sr[i] <= r_vld_sr[i-1];
            end
            if (w_issue) begin
                r_bin  <= r_next[9:0];
                r_next <= r_next + 11'd1;
            end

            if (w_push) begin
                r_fifo[r_wr_ptr] <= i_hist_data;
                r_wr_ptr         <= f_inc(r_wr_ptr);
`ifdef HISTO_SUM_EN
                r_sum            <= r_sum + {8'h00, i_hist_data};
`endif
            end
            if (w_pop) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase

            if (w_pop) begin
                r_data    <= {8'h00, r_fifo[r_rd_ptr]};
                r_valid   <= 1'b1;
                r_sof     <= 1'b0;
                r_eof     <= !SUM_EN && (r_out_idx == LAST_BIN);
                r_out_idx <= r_out_idx + 11'd1;
            end else if (w_hs) begin
                r_valid <= 1'b0;
                r_sof   <= 1'b0;
                r_eof   <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_busy       <= 1'b1;
                        r_settle_cnt <= '0;
                        r_next       <= 11'd0;
`ifdef HISTO_SUM_EN
                        r_sum        <= 32'd0;
`endif
                        r_state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_settle_cnt == SW'(SETTLE - 1)) begin
                        r_data  <= {16'hA55A, r_frame_cnt};
                        r_valid <= 1'b1;
                        r_sof   <= 1'b1;
                        r_eof   <= 1'b0;
                        r_state <= S_HEADER;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SW'(1);
                    end
                end
                // Read mode starts together with bin 0 so a stale address is never read-cleared.
                S_HEADER: begin
                    if (w_hs) begin
                        r_rw      <= 1'b0;
                        r_out_idx <= 11'd0;
                        r_state   <= (NUM_BINS == 1) ? S_FLUSH : S_READ;
                    end
                end
                S_READ: begin
                    if (w_issue && (r_next == LAST_BIN)) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (w_flush_done) begin
                        r_rw <= 1'b1;
`ifdef HISTO_SUM_EN
                        r_data  <= r_sum;
                        r_valid <= 1'b1;
                        r_sof   <= 1'b0;
                        r_eof   <= 1'b1;
                        r_state <= S_TRAILER;
`else
                        r_state <= S_DONE;
`endif
                    end
                end
`ifdef HISTO_SUM_EN
                S_TRAILER: begin
                    if (w_hs) begin
                        r_state <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_hist_rw   = r_rw;
    assign o_hist_bin  = r_bin;
    assign o_busy      = r_busy;
    assign o_frame_cnt = r_frame_cnt;
    assign o_drop_cnt  = r_drop_cnt;
    assign m.data      = r_data;
    assign m.valid     = r_valid;
    assign m.sof       = r_sof;
    assign m.eof       = r_eof;

    histo_readout_chk #(.FIFO_DEPTH(FIFO_DEPTH), .CW(CW)) u_chk (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_cnt   (r_cnt),
        .i_valid (r_valid),
        .i_ready (m.ready),
        .i_beat  ({r_data, r_sof, r_eof})
    );
endmodule

// Simulation-only protocol checks for histo_readout: FIFO overflow and output hold under backpressure.
module histo_readout_chk #(
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          i_push,
    input logic          i_pop,
    input logic [CW-1:0] i_cnt,
    input logic          i_valid,
    input logic          i_ready,
    input logic [33:0]   i_beat
);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && !i_pop && (i_cnt == CW'(FIFO_DEPTH))));

    a_hold: assert property (@(posedge clk) disable iff (rst)
        (i_valid && !i_ready) |=> (i_valid && $stable(i_beat)));
endmodule

// File: tb/tb_histo_readout.sv
// Directed bench for histo_readout with a read-clear accumulator model and a stream monitor.
module tb_histo_readout;
    localparam int NB = 1024;
`ifdef HISTO_SUM_EN
    localparam bit SUM = 1'b1;
`else
    localparam bit SUM = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        done = 1'b0;
    logic        rw;
    logic [9:0]  bin;
    logic [23:0] hdata;
    logic        busy;
    logic [15:0] fcnt;
    logic [7:0]  dcnt;

    histo_readout_if u_if ();

    histo_readout dut (
        .clk          (clk),
        .rst          (rst),
        .i_histo_done (done),
        .o_hist_rw    (rw),
        .o_hist_bin   (bin),
        .i_hist_data  (hdata),
        .m            (u_if),
        .o_busy       (busy),
        .o_frame_cnt  (fcnt),
        .o_drop_cnt   (dcnt)
    );

    always #5 clk = ~clk;

    // Accumulator model: one-register read path, each read clears the bin.
    logic [23:0] mem [0:NB-1];
    int          pre_mode = 0;
    logic        pre_go = 1'b0;
    always @(posedge clk) begin
        if (pre_go) begin
            for (int k = 0; k < NB; k++) mem[k] <= (pre_mode == 0) ? 24'(k) : 24'hFFFFFF;
        end else if (!rw) begin
            hdata    <= mem[bin];
            mem[bin] <= 24'h0;
        end
    end

    // Stream capture and address-issue tracking.
    word_t q[$];
    logic       prev_rw = 1'b1;
    logic [9:0] prev_bin = 10'd0;
    int issue_cnt = 0, order_err = 0, rise_size = 0;
    always @(posedge clk) begin
        prev_rw  <= rw;
        prev_bin <= bin;
        if (!rst && prev_rw && !rw) begin
            issue_cnt <= 1;
            order_err <= (bin != 10'd0) ? 1 : 0;
        end else if (!rst && !rw && (bin != prev_bin)) begin
            issue_cnt <= issue_cnt + 1;
            if (bin != prev_bin + 10'd1) order_err <= order_err + 1;
        end
        if (!rst && !prev_rw && rw) rise_size <= q.size();
        if (!rst && u_if.valid && u_if.ready) q.push_back({u_if.data, u_if.sof, u_if.eof});
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_bin(input int mode, input int k);
        case (mode)
            0:       return 24'(k);
            1:       return 24'h0;
            2:       return 24'hFFFFFF;
            default: return (k <= 500) ? 24'h0 : 24'(k);
        endcase
    endfunction

    task automatic check_packet(input int base, input logic [15:0] fc, input int mode, input string tag);
        int n_exp, n_got, bad_d, bad_f;
        logic [31:0] sum, expw;
        word_t w;
        n_exp = NB + 1 + (SUM ? 1 : 0);
        n_got = q.size() - base;
        bad_d = 0;
        bad_f = 0;
        sum = 32'h0;
        check(32'(n_got), 32'(n_exp), {tag, "_len"});
        if (n_got >= n_exp) begin
            check(q[base].d, {16'hA55A, fc}, {tag, "_hdr"});
            check({31'h0, q[base].s}, 32'h1, {tag, "_sof"});
            for (int k = 0; k < NB; k++) begin
                w = q[base + 1 + k];
                expw = {8'h00, exp_bin(mode, k)};
                sum = sum + expw;
                if (w.d !== expw) bad_d++;
                if ((w.s !== 1'b0) || (w.e !== ((k == NB - 1) && !SUM))) bad_f++;
            end
            if (q[base].e !== 1'b0) bad_f++;
            check(32'(bad_d), 32'h0, {tag, "_data_errs"});
            check(32'(bad_f), 32'h0, {tag, "_flag_errs"});
            if (SUM) begin
                w = q[base + NB + 1];
                check(w.d, sum, {tag, "_trailer"});
                check({30'h0, w.s, w.e}, 32'h1, {tag, "_trailer_flags"});
            end
        end
    endtask

    task automatic preload(input int mode);
        @(negedge clk);
        pre_mode = mode;
        pre_go = 1'b1;
        @(negedge clk);
        pre_go = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic run_sweep(input bit rnd, input int pstart, input int npulse, output int cyc);
        cyc = 0;
        while (cyc < 4000) begin
            @(negedge clk);
            cyc++;
            u_if.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            done = (npulse > 0) && (cyc >= pstart) && (cyc < pstart + 2 * npulse)
                   && (((cyc - pstart) % 2) == 0);
            if (!busy) break;
        end
        done = 1'b0;
        u_if.ready = 1'b1;
        check(32'(cyc < 4000), 32'h1, "sweep_timeout");
    endtask

    initial begin
        int base, cyc, k;
        u_if.ready = 1'b1;
        repeat (3) @(negedge clk);
        check({31'h0, rw}, 32'h1, "rst_rw");
        check({22'h0, bin}, 32'h0, "rst_bin");
        check({29'h0, u_if.valid, u_if.sof, u_if.eof}, 32'h0, "rst_stream");
        check({31'h0, busy}, 32'h0, "rst_busy");
        check({8'h0, fcnt, dcnt}, 32'h0, "rst_counters");
        rst = 1'b0;

        // Ramp pattern, full throughput, settle and read-mode timing.
        preload(0);
        base = q.size();
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check({30'h0, busy, rw}, 32'h3, "start_busy_rw");
        repeat (3) @(negedge clk);
        check({30'h0, u_if.valid, rw}, 32'h1, "settle_idle");
        @(negedge clk);
        check({30'h0, u_if.valid, rw}, 32'h3, "header_valid_rw");
        check(u_if.data, 32'hA55A0000, "header_word");
        @(negedge clk);
        check({31'h0, rw}, 32'h0, "read_mode");
        run_sweep(1'b0, 0, 0, cyc);
        check(32'(cyc + 1 <= 1031), 32'h1, "throughput");
        check_packet(base, 16'd0, 0, "t1");
        check({16'h0, fcnt}, 32'd1, "t1_frame_cnt");
        check(32'(issue_cnt), 32'(NB), "t1_issues");
        check(32'(order_err), 32'h0, "t1_issue_order");
        check(32'(rise_size - base), 32'(NB + 1), "t1_rw_after_last");

        // Immediate second readout sees cleared bins.
        base = q.size();
        pulse_start();
        run_sweep(1'b0, 0, 0, cyc);
        check_packet(base, 16'd1, 1, "t2");
        check({16'h0, fcnt}, 32'd2, "t2_frame_cnt");

        // Random backpressure with three ignored done pulses.
        preload(0);
        base = q.size();
        pulse_start();
        run_sweep(1'b1, 100, 3, cyc);
        check_packet(base, 16'd2, 0, "t3");
        check({24'h0, dcnt}, 32'd3, "t3_drop_cnt");
        check(32'(issue_cnt), 32'(NB), "t3_issues");
        check(32'(order_err), 32'h0, "t3_issue_order");
        check(32'(rise_size - base), 32'(NB + 1), "t3_rw_after_last");
        repeat (20) @(negedge clk);
        check({31'h0, busy}, 32'h0, "t3_no_restart");
        check(32'(q.size() - base), 32'(NB + 1 + (SUM ? 1 : 0)), "t3_single_packet");
        check({16'h0, fcnt}, 32'd3, "t3_frame_cnt");

        // 300 more ignored pulses saturate the drop counter.
        pulse_start();
        run_sweep(1'b0, 10, 300, cyc);
        check({24'h0, dcnt}, 32'hFF, "t4_drop_sat");
        check({16'h0, fcnt}, 32'd4, "t4_frame_cnt");

        // Reset in the middle of the sweep, then a clean packet.
        preload(0);
        pulse_start();
        k = 0;
        while ((bin != 10'd500) && (k < 2000)) begin
            @(negedge clk);
            k++;
        end
        check(32'(k < 2000), 32'h1, "t5_reach_bin500");
        check({31'h0, u_if.valid}, 32'h1, "t5_valid_at_500");
        rst = 1'b1;
        @(negedge clk);
        check({29'h0, u_if.valid, rw, busy}, 32'h2, "t5_rst_valid_rw_busy");
        check({8'h0, fcnt, dcnt}, 32'h0, "t5_rst_counters");
        rst = 1'b0;
        base = q.size();
        pulse_start();
        run_sweep(1'b0, 0, 0, cyc);
        check_packet(base, 16'd0, 3, "t5");
        check({16'h0, fcnt}, 32'd1, "t5_frame_cnt");

        // Saturated counts exercise sum wrap.
        preload(1);
        base = q.size();
        pulse_start();
        run_sweep(1'b0, 0, 0, cyc);
        check_packet(base, 16'd1, 2, "t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
